ez8_boot_ctrl: RTL and testbench

//  Byte-stream command controller that sequences the ez8_cpu: loads instruction memory through
//  the CPU's instr_write* port and drives cpu reset/pause (run, halt, single-step, reset).

---
 rtl/ez8_boot_pkg.sv | 22 ++
 rtl/ez8_boot_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_ez8_boot_ctrl.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ez8_boot_pkg.sv
// Shared opcodes and controller state encoding for the ez8 boot/command controller.
package ez8_boot_pkg;

  localparam logic [7:0] OP_LOAD  = 8'h01;
  localparam logic [7:0] OP_RUN   = 8'h02;
  localparam logic [7:0] OP_HALT  = 8'h03;
  localparam logic [7:0] OP_STEP  = 8'h04;
  localparam logic [7:0] OP_RESET = 8'h05;

  typedef enum logic [3:0] {
    S_IDLE       = 4'd0,
    S_LD_AH      = 4'd1,
    S_LD_AL      = 4'd2,
    S_LD_NH      = 4'd3,
    S_LD_NL      = 4'd4,
    S_LD_DH      = 4'd5,
    S_LD_DL      = 4'd6,
    S_RST_HOLD   = 4'd7,
    S_STEP_PULSE = 4'd8
  } state_e;

endpackage

// File: rtl/ez8_boot_ctrl.sv
// Byte-stream command controller: loads ez8_cpu instruction memory and drives
// its reset/pause lines (run, halt, single-step, reset).
//
// Handshake: a byte on rx_data is consumed on a rising clk edge where
// rx_valid & rx_ready are both 1. rx_ready is registered and never depends
// on rx_valid; rx_data must be held stable while rx_valid is 1 and not taken.
module ez8_boot_ctrl
  import ez8_boot_pkg::*;
#(
  parameter int ADDR_WIDTH   = 12,
  parameter int DATA_WIDTH   = 16,
  parameter int RESET_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic                  cpu_reset,
  output logic                  pause,
  output logic [ADDR_WIDTH-1:0] instr_writeaddr,
  output logic [DATA_WIDTH-1:0] instr_writedata,
  output logic                  instr_write_en,
  output logic                  running,
  output logic                  cmd_err,
  output state_e                dbg_state
);

  // Hold counter counts RESET_CYCLES-1 down to 0 while in S_RST_HOLD.
  localparam int HOLD_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [11:0]           len_q, len_d;
  logic [7:0]            hi_q, hi_d;
  logic [HOLD_W-1:0]     hold_q, hold_d;
  logic                  cpu_reset_q, cpu_reset_d;
  logic                  pause_q, pause_d;
  logic                  running_q, running_d;
  logic                  err_q, err_d;
  logic                  ready_q, ready_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  accept;

  assign accept = rx_valid & ready_q;

  // Next-state, counters and registered outputs of the command FSM.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    len_d       = len_q;
    hi_d        = hi_q;
    hold_d      = hold_q;
    cpu_reset_d = cpu_reset_q;
    pause_d     = pause_q;
    running_d   = running_q;
    err_d       = err_q;
    we_d        = 1'b0;
    waddr_d     = waddr_q;
    wdata_d     = wdata_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (rx_data)
            OP_LOAD: begin
              cpu_reset_d = 1'b1;
              pause_d     = 1'b1;
              running_d   = 1'b0;
              state_d     = S_LD_AH;
            end
            OP_RUN: begin
              cpu_reset_d = 1'b0;
              pause_d     = 1'b0;
              running_d   = 1'b1;
            end
            OP_HALT: begin
              pause_d   = 1'b1;
              running_d = 1'b0;
            end
            OP_STEP: begin
              cpu_reset_d = 1'b0;
              pause_d     = 1'b0;
              running_d   = 1'b0;
              state_d     = S_STEP_PULSE;
            end
            OP_RESET: begin
              cpu_reset_d = 1'b1;
              pause_d     = 1'b1;
              running_d   = 1'b0;
              hold_d      = HOLD_W'(RESET_CYCLES - 1);
              state_d     = S_RST_HOLD;
            end
            default: err_d = 1'b1;
          endcase
        end
      end
      S_LD_AH: if (accept) begin
        addr_d  = ADDR_WIDTH'({rx_data[3:0], addr_q[7:0]});
        state_d = S_LD_AL;
      end
      S_LD_AL: if (accept) begin
        addr_d  = ADDR_WIDTH'({addr_q[11:8], rx_data});
        state_d = S_LD_NH;
      end
      S_LD_NH: if (accept) begin
        len_d   = {rx_data[3:0], len_q[7:0]};
        state_d = S_LD_NL;
      end
      S_LD_NL: if (accept) begin
        len_d   = {len_q[11:8], rx_data};
        state_d = ({len_q[11:8], rx_data} == 12'd0) ? S_IDLE : S_LD_DH;
      end
      S_LD_DH: if (accept) begin
        hi_d    = rx_data;
        state_d = S_LD_DL;
      end
      S_LD_DL: if (accept) begin
        we_d    = 1'b1;
        waddr_d = addr_q;
        wdata_d = DATA_WIDTH'({hi_q, rx_data});
        addr_d  = addr_q + ADDR_WIDTH'(1);
        len_d   = len_q - 12'd1;
        state_d = (len_q == 12'd1) ? S_IDLE : S_LD_DH;
      end
      S_RST_HOLD: begin
        if (hold_q == '0) state_d = S_IDLE;
        else              hold_d  = hold_q - HOLD_W'(1);
      end
      S_STEP_PULSE: begin
        pause_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Byte intake is closed only while holding reset or pulsing a step.
    ready_d = !((state_d == S_RST_HOLD) || (state_d == S_STEP_PULSE));
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      len_q       <= '0;
      hi_q        <= '0;
      hold_q      <= '0;
      cpu_reset_q <= 1'b1;
      pause_q     <= 1'b1;
      running_q   <= 1'b0;
      err_q       <= 1'b0;
      ready_q     <= 1'b0;
      we_q        <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      hi_q        <= hi_d;
      hold_q      <= hold_d;
      cpu_reset_q <= cpu_reset_d;
      pause_q     <= pause_d;
      running_q   <= running_d;
      err_q       <= err_d;
      ready_q     <= ready_d;
      we_q        <= we_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
    end
  end

  assign rx_ready        = ready_q;
  assign cpu_reset       = cpu_reset_q;
  assign pause           = pause_q;
  assign running         = running_q;
  assign cmd_err         = err_q;
  assign instr_write_en  = we_q;
  assign instr_writeaddr = waddr_q;
  assign instr_writedata = wdata_q;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_ez8_boot_ctrl.sv
// Self-checking bench for ez8_boot_ctrl: directed scenarios plus random
// command streams compared cycle by cycle against a command-interpreter model.
module tb_ez8_boot_ctrl;
  import ez8_boot_pkg::*;

  localparam int RC = 4;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready, cpu_reset, pause, instr_write_en, running, cmd_err;
  logic [11:0] instr_writeaddr;
  logic [15:0] instr_writedata;
  state_e      dbg_state;

  always #5 clk = ~clk;

  ez8_boot_ctrl #(.ADDR_WIDTH(12), .DATA_WIDTH(16), .RESET_CYCLES(RC)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .cpu_reset(cpu_reset), .pause(pause),
    .instr_writeaddr(instr_writeaddr), .instr_writedata(instr_writedata),
    .instr_write_en(instr_write_en), .running(running), .cmd_err(cmd_err),
    .dbg_state(dbg_state)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------- scoreboard for literal write lists ----------------
  logic [27:0] exp_q[$];
  logic [27:0] got_q[$];

  task automatic compare_writes(input string name);
    check({name, "_count"}, got_q.size(), exp_q.size());
    while (exp_q.size() > 0 && got_q.size() > 0)
      check({name, "_write"}, got_q.pop_front(), exp_q.pop_front());
    exp_q.delete();
    got_q.delete();
  endtask

  // ---------------- behavioural model ----------------
  // Interprets the accepted byte stream by position within the current
  // command; expected outputs describe the DUT after the coming clock edge.
  logic        m_valid = 1'b0;
  logic        e_rst, e_pause, e_run, e_err, e_rdy, e_we;
  logic [11:0] e_addr;
  logic [15:0] e_data;
  int          m_pos, m_block, m_len, m_base;
  logic        m_step;
  logic [7:0]  m_hdr[4];
  logic [7:0]  m_hi;

  always @(negedge clk) begin
    if (m_valid) begin
      check("rx_ready",  rx_ready,  e_rdy);
      check("cpu_reset", cpu_reset, e_rst);
      check("pause",     pause,     e_pause);
      check("running",   running,   e_run);
      check("cmd_err",   cmd_err,   e_err);
      check("write_en",  instr_write_en, e_we);
      if (e_we) begin
        check("write_addr", instr_writeaddr, e_addr);
        check("write_data", instr_writedata, e_data);
      end
    end
    if (instr_write_en === 1'b1) got_q.push_back({instr_writeaddr, instr_writedata});

    if (reset) begin
      e_rst = 1; e_pause = 1; e_run = 0; e_err = 0; e_rdy = 0; e_we = 0;
      e_addr = 0; e_data = 0; m_pos = 0; m_block = 0; m_step = 0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      automatic logic acc = rx_valid && e_rdy;
      automatic logic nrdy = 1'b1;
      e_we = 0;
      if (m_step) begin e_pause = 1; m_step = 0; end
      if (m_block > 0) begin m_block--; if (m_block > 0) nrdy = 1'b0; end
      if (acc) begin
        if (m_pos == 0) begin
          case (rx_data)
            8'h01: begin e_rst = 1; e_pause = 1; e_run = 0; m_pos = 1; end
            8'h02: begin e_rst = 0; e_pause = 0; e_run = 1; end
            8'h03: begin e_pause = 1; e_run = 0; end
            8'h04: begin e_rst = 0; e_pause = 0; e_run = 0; m_step = 1; nrdy = 1'b0; end
            8'h05: begin e_rst = 1; e_pause = 1; e_run = 0; m_block = RC; nrdy = 1'b0; end
            default: e_err = 1;
          endcase
        end else if (m_pos <= 4) begin
          m_hdr[m_pos-1] = rx_data;
          if (m_pos == 4) begin
            m_base = {m_hdr[0][3:0], m_hdr[1]};
            m_len  = {m_hdr[2][3:0], rx_data};
            m_pos  = (m_len == 0) ? 0 : 5;
          end else m_pos++;
        end else begin
          automatic int k = m_pos - 5;
          if (k % 2 == 0) begin
            m_hi = rx_data;
            m_pos++;
          end else begin
            e_we   = 1;
            e_addr = 12'((m_base + k / 2) % 4096);
            e_data = {m_hi, rx_data};
            if (k / 2 + 1 == m_len) m_pos = 0;
            else m_pos++;
          end
        end
      end
      e_rdy = nrdy;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    rx_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    rx_data  = b;
    rx_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (rx_ready === 1'b1) break;
      n++;
      if (n > 50) begin
        check("handshake_timeout", 32'd0, 32'd1);
        break;
      end
    end
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic pulse_reset(input int n);
    rx_valid = 1'b0;
    reset = 1'b1;
    repeat (n) begin @(posedge clk); #1; end
    reset = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  function automatic int rgap();
    return ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 2);
  endfunction

  // Random LOAD; abort_at >= 0 asserts reset after that many bytes.
  task automatic rand_load(input int abort_at);
    logic [11:0] a;
    int          len;
    logic [7:0]  bytes[$];
    a   = ($urandom_range(0, 1) == 0) ? 12'(12'hFFC + $urandom_range(0, 3)) : 12'($urandom_range(0, 4095));
    len = $urandom_range(0, 5);
    bytes.push_back(OP_LOAD);
    bytes.push_back({4'($urandom_range(0, 15)), a[11:8]});
    bytes.push_back(a[7:0]);
    bytes.push_back({4'($urandom_range(0, 15)), 4'h0});
    bytes.push_back(8'(len));
    for (int i = 0; i < 2 * len; i++) bytes.push_back(8'($urandom_range(0, 255)));
    for (int i = 0; i < bytes.size(); i++) begin
      if (i == abort_at) begin pulse_reset(1); return; end
      send_byte(bytes[i], rgap());
    end
  endtask

  // ---------------- main sequence ----------------
  int low_cnt;

  initial begin
    idle(3);
    check("rst_cpu_reset", cpu_reset, 1);
    check("rst_pause", pause, 1);
    check("rst_rx_ready", rx_ready, 0);
    check("rst_write_en", instr_write_en, 0);
    check("rst_state", dbg_state, S_IDLE);
    reset = 1'b0;
    idle(2);
    check("ready_after_reset", rx_ready, 1);
    got_q.delete();

    // 1: two-word load back to back
    exp_q.push_back({12'h010, 16'h1234});
    exp_q.push_back({12'h011, 16'hABCD});
    send_byte(8'h01, 0); send_byte(8'h00, 0); send_byte(8'h10, 0);
    send_byte(8'h00, 0); send_byte(8'h02, 0); send_byte(8'h12, 0);
    send_byte(8'h34, 0); send_byte(8'hAB, 0); send_byte(8'hCD, 0);
    idle(3);
    compare_writes("t1");
    check("t1_cpu_reset", cpu_reset, 1);

    // 2: address wrap
    exp_q.push_back({12'hFFF, 16'h0001});
    exp_q.push_back({12'h000, 16'h0002});
    send_byte(8'h01, 0); send_byte(8'h0F, 1); send_byte(8'hFF, 0);
    send_byte(8'h00, 2); send_byte(8'h02, 0); send_byte(8'h00, 0);
    send_byte(8'h01, 1); send_byte(8'h00, 0); send_byte(8'h02, 0);
    idle(3);
    compare_writes("t2");

    // 3: zero-length load then RUN
    send_byte(8'h01, 0); send_byte(8'h00, 0); send_byte(8'h20, 0);
    send_byte(8'h00, 0); send_byte(8'h00, 0);
    send_byte(OP_RUN, 1);
    idle(1);
    compare_writes("t3");
    check("t3_cpu_reset", cpu_reset, 0);
    check("t3_pause", pause, 0);
    check("t3_running", running, 1);

    // 4: single step
    send_byte(OP_STEP, 1);
    check("t4_pause_pulse", pause, 0);
    check("t4_ready_pulse", rx_ready, 0);
    idle(1);
    check("t4_pause_after", pause, 1);
    check("t4_ready_after", rx_ready, 1);
    check("t4_cpu_reset", cpu_reset, 0);

    // 5: reset hold then unknown opcode
    send_byte(OP_RESET, 0);
    low_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (rx_ready === 1'b0) low_cnt++;
      idle(1);
    end
    check("t5_hold_cycles", low_cnt, RC);
    check("t5_cpu_reset", cpu_reset, 1);
    send_byte(8'h7E, 0);
    idle(1);
    check("t5_cmd_err", cmd_err, 1);
    check("t5_state", dbg_state, S_IDLE);

    // 6: reset after a word's hi byte
    send_byte(8'h01, 0); send_byte(8'h00, 0); send_byte(8'h40, 0);
    send_byte(8'h00, 0); send_byte(8'h01, 0); send_byte(8'h55, 0);
    reset = 1'b1;
    idle(1);
    check("t6_cpu_reset", cpu_reset, 1);
    check("t6_cmd_err", cmd_err, 0);
    check("t6_ready", rx_ready, 0);
    check("t6_state", dbg_state, S_IDLE);
    reset = 1'b0;
    idle(3);
    compare_writes("t6");

    // random command streams
    for (int it = 0; it < 300; it++) begin
      automatic int r = $urandom_range(0, 99);
      if (r < 35) begin
        rand_load(($urandom_range(0, 99) < 15) ? $urandom_range(0, 10) : -1);
      end else if (r < 50) send_byte(OP_RUN, rgap());
      else if (r < 60) send_byte(OP_HALT, rgap());
      else if (r < 72) send_byte(OP_STEP, rgap());
      else if (r < 82) send_byte(OP_RESET, rgap());
      else if (r < 88) begin
        logic [7:0] b;
        do b = 8'($urandom_range(0, 255)); while (b >= 8'h01 && b <= 8'h05);
        send_byte(b, rgap());
      end else if (r < 92) pulse_reset($urandom_range(1, 2));
      else idle($urandom_range(1, 4));
    end
    idle(8);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
